uart_tx_sched: RTL

Round-robin scheduler that shares one `uart_tx` transmitter between `N_REQ` byte producers. It sits between the requesters and `uart_tx` in the UART top level. It accepts one byte at a time from the winning requester and launches the frame with a one-cycle start pulse. It then tracks the transmitter's busy flag until the frame completes, and enforces a programmable idle gap between frames.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/uart_tx_sched.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Purpose : shared types and constants for the UART transmit-side blocks.
// Latency : n/a (declarations only).
// Backpress: n/a.
package uart_pkg;

  // Width of one UART payload byte.
  localparam int BYTE_W = 8;

  // Transmit scheduler states. The encoding is fixed so that waveform and
  // debug tools decode the same values everywhere.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } sched_state_e;

  // Larger of two integers, used for sizing shared counters.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : combinational round-robin pick; searches upward from last_idx+1, wrapping.
// Latency : zero cycles (pure combinational).
// Backpress: none; the caller decides when a pick is consumed and updates last_idx.
//
// Ports:
//   req_vld  - per-requester request vector
//   last_idx - index of the previous winner (search starts just above it)
//   win_idx  - selected requester (0 when nothing is valid)
//   win_any  - at least one requester is valid
module rr_arbiter #(
  parameter int  N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_vld,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_any
);

  int   idx;
  logic found;

  // Walk the N_REQ positions after last_idx; the first valid one wins, so the
  // previous winner is checked last and cannot starve anyone.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_idx) + i) % N_REQ;
      if (!found && req_vld[idx]) begin
        found   = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
  end

  assign win_any = found;

endmodule

// File: rtl/uart_tx_sched.sv
// Purpose : shares one uart_tx between N_REQ byte producers, round-robin, with a post-frame idle gap.
// Latency : byte captured at the edge valid is seen in IDLE; start/ready pulse the following cycle.
// Backpress: one held byte only; requests outside IDLE are ignored and wait for the next arbitration.
//
// Ports:
//   i_clk, i_reset        - clock, asynchronous active-low reset
//   i_req_valid/_data     - per-requester pending byte (requester k at bits [8k+7:8k])
//   o_req_ready           - one-cycle one-hot acknowledge to the winner
//   o_tx_start/o_tx_data  - start pulse and byte to uart_tx (data held until next capture)
//   i_tx_busy             - uart_tx frame in progress
//   o_grant_id            - owner of the current/last frame
//   o_active              - scheduler not IDLE
//   o_err                 - sticky start-timeout flag
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int  N_REQ         = 4,
  parameter int  GAP_CYCLES    = 16,
  parameter int  START_TIMEOUT = 8,
  localparam int IDX_W         = $clog2(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [BYTE_W*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_tx_start,
  output logic [BYTE_W-1:0]       o_tx_data,
  input  logic                    i_tx_busy,
  output logic [IDX_W-1:0]        o_grant_id,
  output logic                    o_active,
  output logic                    o_err
);

  // One counter serves both the start timeout and the idle gap; it is never
  // used for both at once. Sized so the larger terminal count fits exactly.
  localparam int CNT_W = max2($clog2(max2(GAP_CYCLES, START_TIMEOUT) + 1), 1);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic              err_q, err_d;
  logic              active_q, active_d;

  logic [IDX_W-1:0]  arb_win;
  logic              arb_any;
  logic [CNT_W:0]    cnt_inc;
  logic [BYTE_W-1:0] req_byte [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_byte[k] = i_req_data[k*BYTE_W +: BYTE_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_vld  (i_req_valid),
    .last_idx (last_q),
    .win_idx  (arb_win),
    .win_any  (arb_any)
  );

  // One bit wider than the counter so the timeout compare cannot wrap.
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    start_d = 1'b0;
    ready_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          // Capture now; start and ready are registered so they land together
          // in the LAUNCH cycle.
          state_d          = ST_LAUNCH;
          last_d           = arb_win;
          grant_d          = arb_win;
          data_d           = req_byte[arb_win];
          start_d          = 1'b1;
          ready_d[arb_win] = 1'b1;
        end
      end

      ST_LAUNCH: begin
        state_d = ST_WAIT_BUSY;
        cnt_d   = '0;
      end

      ST_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_inc >= (CNT_W+1)'(START_TIMEOUT)) begin
          // Transmitter never acknowledged: flag it and abandon the byte.
          err_d   = 1'b1;
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end

      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end

      ST_GAP: begin
        // Counter stops at the terminal value; the exit happens on that cycle.
        if (cnt_q >= CNT_W'(GAP_CYCLES)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      last_q   <= IDX_W'(N_REQ - 1);
      grant_q  <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      ready_q  <= '0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_tx_start  = start_q;
  assign o_tx_data   = data_q;
  assign o_grant_id  = grant_q;
  assign o_active    = active_q;
  assign o_err       = err_q;

  // Structural invariants of the handshake.
  a_ready_onehot0 : assert property (@(posedge i_clk) disable iff (!i_reset)
    $onehot0(o_req_ready));
  a_start_has_ready : assert property (@(posedge i_clk) disable iff (!i_reset)
    o_tx_start |-> $onehot(o_req_ready));
  a_start_single : assert property (@(posedge i_clk) disable iff (!i_reset)
    o_tx_start |=> !o_tx_start);

endmodule
